// File: rtl/pw_conv_post_process.sv
// Packs pairs of 72-bit PW-conv result beats into 144-bit feature-map words.
// Optional macro PWPOST_RELU_EN clamps negative input lanes to zero before packing.
module pw_conv_post_process #(
  parameter int unsigned LANE_W    = 9,
  parameter int unsigned IN_LANES  = 8,
  parameter int unsigned PAD_VALUE = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANE_W*IN_LANES-1:0]   in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*LANE_W*IN_LANES-1:0] out_data,
  output logic                         out_last,
  output logic [CNT_W-1:0]             word_cnt
);

  localparam int unsigned InW = LANE_W * IN_LANES;

  typedef enum logic [0:0] {StLow, StHigh} state_e;

  state_e             state_q, state_d;
  logic [InW-1:0]     hold_q, hold_d;
  logic [2*InW-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [InW-1:0]     din;
  logic [InW-1:0]     pad_word;
  logic               accept;
  logic               xfer;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign word_cnt  = word_cnt_q;

  // Lane conditioning shared by the hold and direct-load paths.
  always_comb begin
    din = in_data;
`ifdef PWPOST_RELU_EN
    for (int unsigned k = 0; k < IN_LANES; k++) begin
      if (in_data[k*LANE_W+LANE_W-1]) begin
        din[k*LANE_W +: LANE_W] = '0;
      end
    end
`endif
  end

  always_comb begin
    pad_word = '0;
    for (int unsigned k = 0; k < IN_LANES; k++) begin
      pad_word[k*LANE_W +: LANE_W] = LANE_W'(PAD_VALUE);
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_ready;
    word_cnt_d  = word_cnt_q;

    if (xfer) begin
      word_cnt_d = out_last_q ? '0 : word_cnt_q + CNT_W'(1);
    end

    if (accept) begin
      unique case (state_q)
        StLow: begin
          if (in_last) begin
            // Odd-length frame: the final beat closes the frame on its own.
            out_data_d  = {pad_word, din};
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            hold_d  = din;
            state_d = StHigh;
          end
        end
        StHigh: begin
          out_data_d  = {din, hold_q};
          out_last_d  = in_last;
          out_valid_d = 1'b1;
          state_d     = StLow;
        end
        default: state_d = StLow;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StLow;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

endmodule
